// File: rtl/surf_dout_packer_pkg.sv
// Shared SURF definitions: packer FSM states and the trailer word layout.
// The trailer is {tag[7:0], trunc, event_num[10:0], byte_count[11:0]}.
package surf_dout_packer_pkg;

  typedef enum logic {
    PACK    = 1'b0,
    TRAILER = 1'b1
  } pk_state_e;

  localparam int TRL_TAG_W     = 8;
  localparam int TRL_TRUNC_W   = 1;
  localparam int TRL_EVNUM_W   = 11;
  localparam int TRL_CNT_W     = 12;

  localparam int TRL_CNT_LSB   = 0;
  localparam int TRL_EVNUM_LSB = TRL_CNT_LSB + TRL_CNT_W;
  localparam int TRL_TRUNC_LSB = TRL_EVNUM_LSB + TRL_EVNUM_W;
  localparam int TRL_TAG_LSB   = TRL_TRUNC_LSB + TRL_TRUNC_W;

  function automatic logic [31:0] mk_trailer(
    input logic [TRL_TAG_W-1:0]   tag,
    input logic                   trunc,
    input logic [TRL_EVNUM_W-1:0] evnum,
    input logic [TRL_CNT_W-1:0]   cnt
  );
    logic [31:0] t;
    t = '0;
    t[TRL_TAG_LSB   +: TRL_TAG_W]   = tag;
    t[TRL_TRUNC_LSB +: TRL_TRUNC_W] = trunc;
    t[TRL_EVNUM_LSB +: TRL_EVNUM_W] = evnum;
    t[TRL_CNT_LSB   +: TRL_CNT_W]   = cnt;
    return t;
  endfunction

endpackage

// File: rtl/surf_dout_packer.sv
// Packs a SURF DOUT byte stream little-endian into 32-bit words, closing each frame with a trailer.
// One cycle byte-to-word latency; a full output register stalls s_dout_tready until m_ev accepts it.
module surf_dout_packer
  import surf_dout_packer_pkg::*;
#(
  parameter logic [7:0] TRAILER_TAG = 8'hA5,
  parameter int         MAX_BYTES   = 4095
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [7:0]  s_dout_tdata,
  input  logic        s_dout_tvalid,
  output logic        s_dout_tready,
  input  logic        s_dout_tlast,
  output logic [31:0] m_ev_tdata,
  output logic        m_ev_tvalid,
  input  logic        m_ev_tready,
  output logic        m_ev_tlast,
  output logic [10:0] event_num_o,
  output logic        trunc_o
);

  localparam logic [11:0] MAX_CNT = 12'(MAX_BYTES);

  pk_state_e   state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [1:0]  lane_q, lane_d;
  logic [11:0] cnt_q, cnt_d;
  logic        trunc_q, trunc_d;
  logic [10:0] ev_q, ev_d;
  logic [31:0] mdat_q, mdat_d;
  logic        mvld_q, mvld_d;
  logic        mlast_q, mlast_d;
  logic        trunc_pls_q, trunc_pls_d;
  logic [1:0]  warm_q, warm_d;

  logic        out_free;
  logic        s_hs;
  logic [31:0] word_w;

  // Input is held off until the second edge after reset release.
  assign out_free      = !mvld_q || m_ev_tready;
  assign s_dout_tready = warm_q[1] && (state_q == PACK) && out_free;
  assign s_hs          = s_dout_tvalid && s_dout_tready;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    lane_d      = lane_q;
    cnt_d       = cnt_q;
    trunc_d     = trunc_q;
    ev_d        = ev_q;
    mdat_d      = mdat_q;
    mvld_d      = mvld_q;
    mlast_d     = mlast_q;
    trunc_pls_d = 1'b0;
    warm_d      = {warm_q[0], 1'b1};
    word_w      = acc_q | ({24'd0, s_dout_tdata} << {lane_q, 3'b000});

    if (m_ev_tready) begin
      mvld_d  = 1'b0;
      mlast_d = 1'b0;
    end

    case (state_q)
      PACK: begin
        if (s_hs) begin
          if (cnt_q != MAX_CNT) begin
            cnt_d = cnt_q + 12'd1;
            if (lane_q == 2'd3 || s_dout_tlast) begin
              mdat_d  = word_w;
              mvld_d  = 1'b1;
              mlast_d = 1'b0;
              acc_d   = '0;
              lane_d  = 2'd0;
            end else begin
              acc_d  = word_w;
              lane_d = lane_q + 2'd1;
            end
          end else begin
            // Over-limit byte: dropped, but a tlast here still flushes the partial word.
            trunc_d     = 1'b1;
            trunc_pls_d = !trunc_q;
            if (s_dout_tlast && lane_q != 2'd0) begin
              mdat_d  = acc_q;
              mvld_d  = 1'b1;
              mlast_d = 1'b0;
              acc_d   = '0;
              lane_d  = 2'd0;
            end
          end
          if (s_dout_tlast) begin
            state_d = TRAILER;
          end
        end
      end
      TRAILER: begin
        if (mvld_q && mlast_q) begin
          if (m_ev_tready) begin
            state_d = PACK;
            cnt_d   = '0;
            trunc_d = 1'b0;
            ev_d    = ev_q + 11'd1;
          end
        end else if (out_free) begin
          mdat_d  = mk_trailer(TRAILER_TAG, trunc_q, ev_q, cnt_q);
          mvld_d  = 1'b1;
          mlast_d = 1'b1;
        end
      end
      default: state_d = PACK;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= PACK;
      acc_q       <= '0;
      lane_q      <= '0;
      cnt_q       <= '0;
      trunc_q     <= 1'b0;
      ev_q        <= '0;
      mdat_q      <= '0;
      mvld_q      <= 1'b0;
      mlast_q     <= 1'b0;
      trunc_pls_q <= 1'b0;
      warm_q      <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      lane_q      <= lane_d;
      cnt_q       <= cnt_d;
      trunc_q     <= trunc_d;
      ev_q        <= ev_d;
      mdat_q      <= mdat_d;
      mvld_q      <= mvld_d;
      mlast_q     <= mlast_d;
      trunc_pls_q <= trunc_pls_d;
      warm_q      <= warm_d;
    end
  end

  assign m_ev_tdata  = mdat_q;
  assign m_ev_tvalid = mvld_q;
  assign m_ev_tlast  = mlast_q;
  assign event_num_o = ev_q;
  assign trunc_o     = trunc_pls_q;

endmodule

// File: tb/tb_surf_dout_packer.sv
// Directed bench for surf_dout_packer built with MAX_BYTES=8: a cycle table plus frame-level sequences.
module tb_surf_dout_packer;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [7:0]  s_dout_tdata = '0;
  logic        s_dout_tvalid = 1'b0;
  logic        s_dout_tready;
  logic        s_dout_tlast = 1'b0;
  logic [31:0] m_ev_tdata;
  logic        m_ev_tvalid;
  logic        m_ev_tready = 1'b1;
  logic        m_ev_tlast;
  logic [10:0] event_num_o;
  logic        trunc_o;

  int errors = 0;
  int checks = 0;
  logic [32:0] mon_q[$];
  int trunc_cnt = 0;

  surf_dout_packer #(.TRAILER_TAG(8'hA5), .MAX_BYTES(8)) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .s_dout_tdata (s_dout_tdata),
    .s_dout_tvalid(s_dout_tvalid),
    .s_dout_tready(s_dout_tready),
    .s_dout_tlast (s_dout_tlast),
    .m_ev_tdata   (m_ev_tdata),
    .m_ev_tvalid  (m_ev_tvalid),
    .m_ev_tready  (m_ev_tready),
    .m_ev_tlast   (m_ev_tlast),
    .event_num_o  (event_num_o),
    .trunc_o      (trunc_o)
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk) begin
    if (aresetn && m_ev_tvalid && m_ev_tready) mon_q.push_back({m_ev_tlast, m_ev_tdata});
  end

  always @(negedge aclk) begin
    if (trunc_o) trunc_cnt++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    int t;
    @(negedge aclk);
    s_dout_tvalid = 1'b1;
    s_dout_tdata  = d;
    s_dout_tlast  = l;
    #1;
    t = 0;
    while (!s_dout_tready && t < 300) begin
      @(negedge aclk);
      #1;
      t++;
    end
    if (t >= 300) begin
      checks++;
      errors++;
      $display("FAIL send_byte timeout: byte %h never accepted, required tready=1", d);
    end
    @(posedge aclk);
  endtask

  task automatic go_idle();
    @(negedge aclk);
    s_dout_tvalid = 1'b0;
    s_dout_tlast  = 1'b0;
  endtask

  task automatic send_frame(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) send_byte(base + 8'(i), (i == n - 1));
    go_idle();
  endtask

  task automatic expect_word(input string name, input logic last, input logic [31:0] dat);
    int t;
    logic [32:0] w;
    t = 0;
    while (mon_q.size() == 0 && t < 300) begin
      @(negedge aclk);
      t++;
    end
    if (mon_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: no output word, expected %h last=%0b", name, dat, last);
    end else begin
      w = mon_q.pop_front();
      chk(name, 64'(w), 64'({last, dat}));
    end
  endtask

  task automatic do_reset();
    @(negedge aclk);
    aresetn = 1'b0;
    s_dout_tvalid = 1'b0;
    s_dout_tlast = 1'b0;
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    repeat (3) @(negedge aclk);
    mon_q.delete();
  endtask

  typedef struct {
    logic        vld;
    logic [7:0]  dat;
    logic        last;
    logic        e_srdy;
    logic        e_mvld;
    logic [31:0] e_mdat;
    logic        e_mlast;
    logic [10:0] e_ev;
  } vec_t;

  vec_t tv[11];
  int   t0;

  initial begin
    tv[0]  = '{1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 11'd0};
    tv[1]  = '{1'b1, 8'h02, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 11'd0};
    tv[2]  = '{1'b1, 8'h03, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 11'd0};
    tv[3]  = '{1'b1, 8'h04, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 11'd0};
    tv[4]  = '{1'b1, 8'h05, 1'b0, 1'b1, 1'b1, 32'h04030201, 1'b0, 11'd0};
    tv[5]  = '{1'b1, 8'h06, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 11'd0};
    tv[6]  = '{1'b1, 8'h07, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 11'd0};
    tv[7]  = '{1'b1, 8'h08, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 11'd0};
    tv[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 32'h08070605, 1'b0, 11'd0};
    tv[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 32'hA5000008, 1'b1, 11'd0};
    tv[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 11'd1};

    // Reset state and the post-release tready hold-off.
    repeat (2) @(negedge aclk);
    #1;
    chk("rst_mvld", m_ev_tvalid, 0);
    chk("rst_mdat", m_ev_tdata, 0);
    chk("rst_mlast", m_ev_tlast, 0);
    chk("rst_ev", event_num_o, 0);
    chk("rst_trunc", trunc_o, 0);
    chk("rst_srdy", s_dout_tready, 0);
    @(negedge aclk);
    aresetn = 1'b1;
    #1;
    chk("rel_srdy0", s_dout_tready, 0);
    @(negedge aclk);
    #1;
    chk("rel_srdy1", s_dout_tready, 0);
    @(negedge aclk);
    #1;
    chk("rel_srdy2", s_dout_tready, 1);

    // 8-byte frame 01..08 at full rate; also exactly MAX_BYTES so no truncation.
    t0 = trunc_cnt;
    for (int i = 0; i < 11; i++) begin
      @(negedge aclk);
      s_dout_tvalid = tv[i].vld;
      s_dout_tdata  = tv[i].dat;
      s_dout_tlast  = tv[i].last;
      #1;
      chk($sformatf("tbl%0d_srdy", i), s_dout_tready, tv[i].e_srdy);
      chk($sformatf("tbl%0d_mvld", i), m_ev_tvalid, tv[i].e_mvld);
      chk($sformatf("tbl%0d_ev", i), event_num_o, tv[i].e_ev);
      if (tv[i].e_mvld) begin
        chk($sformatf("tbl%0d_mdat", i), m_ev_tdata, tv[i].e_mdat);
        chk($sformatf("tbl%0d_mlast", i), m_ev_tlast, tv[i].e_mlast);
      end
    end
    expect_word("tbl_w0", 1'b0, 32'h04030201);
    expect_word("tbl_w1", 1'b0, 32'h08070605);
    expect_word("tbl_trl", 1'b1, 32'hA5000008);
    chk("tbl_trunc_pulses", trunc_cnt - t0, 0);

    // 5-byte frame: second word padded with zeros.
    send_frame(5, 8'h01);
    expect_word("f5_w0", 1'b0, 32'h04030201);
    expect_word("f5_w1", 1'b0, 32'h00000005);
    expect_word("f5_trl", 1'b1, 32'hA5001005);

    // 10-byte frame with MAX_BYTES=8: bytes 9 and 10 dropped, trunc reported.
    t0 = trunc_cnt;
    send_frame(10, 8'h21);
    expect_word("f10_w0", 1'b0, 32'h24232221);
    expect_word("f10_w1", 1'b0, 32'h28272625);
    expect_word("f10_trl", 1'b1, 32'hA5802008);
    repeat (3) @(negedge aclk);
    chk("f10_trunc_pulses", trunc_cnt - t0, 1);
    chk("f10_extra_words", mon_q.size(), 0);
    chk("f10_ev", event_num_o, 3);

    // Output backpressure for 10 cycles with the register full.
    t0 = trunc_cnt;
    m_ev_tready = 1'b0;
    for (int i = 0; i < 4; i++) send_byte(8'h41 + 8'(i), 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge aclk);
      s_dout_tvalid = 1'b1;
      s_dout_tdata  = 8'h45;
      s_dout_tlast  = 1'b0;
      #1;
      chk($sformatf("bp%0d_srdy", i), s_dout_tready, 0);
      chk($sformatf("bp%0d_hold", i), {m_ev_tvalid, m_ev_tdata}, {1'b1, 32'h44434241});
    end
    chk("bp_no_handoff", mon_q.size(), 0);
    @(negedge aclk);
    m_ev_tready = 1'b1;
    #1;
    chk("bp_release_srdy", s_dout_tready, 1);
    @(posedge aclk);
    send_byte(8'h46, 1'b0);
    send_byte(8'h47, 1'b0);
    send_byte(8'h48, 1'b1);
    go_idle();
    expect_word("bp_w0", 1'b0, 32'h44434241);
    expect_word("bp_w1", 1'b0, 32'h48474645);
    expect_word("bp_trl", 1'b1, 32'hA5003008);
    chk("bp_trunc_pulses", trunc_cnt - t0, 0);

    // Reset after byte 3: that frame vanishes, the next starts clean.
    send_byte(8'h51, 1'b0);
    send_byte(8'h52, 1'b0);
    send_byte(8'h53, 1'b0);
    @(negedge aclk);
    aresetn = 1'b0;
    s_dout_tvalid = 1'b0;
    #1;
    chk("mr_ev", event_num_o, 0);
    chk("mr_mvld", m_ev_tvalid, 0);
    @(negedge aclk);
    aresetn = 1'b1;
    repeat (4) @(negedge aclk);
    chk("mr_no_output", mon_q.size(), 0);
    send_frame(4, 8'h61);
    expect_word("mr_w0", 1'b0, 32'h64636261);
    expect_word("mr_trl", 1'b1, 32'hA5000004);

    // 2048 one-byte frames: event number runs 0..2047 and wraps.
    do_reset();
    for (int k = 0; k < 2048; k++) begin
      send_frame(1, 8'(k));
      expect_word($sformatf("b2b%0d_w", k), 1'b0, {24'd0, 8'(k)});
      expect_word($sformatf("b2b%0d_trl", k), 1'b1, {8'hA5, 1'b0, 11'(k), 12'd1});
    end
    @(negedge aclk);
    #1;
    chk("b2b_wrap_ev", event_num_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
